load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_align_unit_if.sv | 29 ++
 rtl/load_align_unit.sv | 162 ++++++++++++++++
 tb/tb_load_align_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// Bus bundle for load_align_unit: request handshake, memory read port and
// response handshake. The unit connects through the slave modport; the
// requester/memory side uses the master modport.
interface load_align_unit_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [AWIDTH-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic              mem_re;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DWIDTH-1:0] resp_data;
  logic              resp_fault;

  modport slave (
    input  req_valid, req_addr, req_funct3, mem_rdata, resp_ready,
    output req_ready, mem_re, mem_addr, resp_valid, resp_data, resp_fault
  );

  modport master (
    output req_valid, req_addr, req_funct3, mem_rdata, resp_ready,
    input  req_ready, mem_re, mem_addr, resp_valid, resp_data, resp_fault
  );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: RISC-V load extraction/extension unit with a one-cycle
// read-latency memory port. Loads are fetched as whole aligned words; the
// addressed bytes are shifted down and sign/zero extended.
// Optional feature macro: MISALIGNED_LOAD_EN. When defined, loads that span
// two words are served with a second read (RD1). When undefined, such loads
// return a fault and RD1 is never entered.
module load_align_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  load_align_unit_if.slave bus
);

  localparam int NB = DWIDTH / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t            state;
  logic [AWIDTH-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [DWIDTH-1:0] resp_data_q;
  logic              resp_fault_q;
`ifdef MISALIGNED_LOAD_EN
  logic [DWIDTH-1:0] beat0;
`endif

  logic [OW-1:0]     off_q;
  logic              mem_re_c;
  logic [AWIDTH-1:0] mem_addr_c;

  assign off_q = addr_q[OW-1:0];

  // LD and LWU exist only on a 64-bit datapath; funct3=111 is never a load.
  function automatic logic legal_f3(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      3'b011, 3'b110:                         return (DWIDTH == 64);
      default:                                return 1'b0;
    endcase
  endfunction

  // True when the access runs past the end of the word it starts in.
  function automatic logic crossing(input logic [OW-1:0] off, input logic [2:0] f3);
    int bytes;
    bytes = 1 << f3[1:0];
    return (int'(off) + bytes) > NB;
  endfunction

  function automatic logic [AWIDTH-1:0] align(input logic [AWIDTH-1:0] a);
    return a & ~AWIDTH'(NB - 1);
  endfunction

  // Shift the two-word window down to the addressed byte, keep the access
  // size and fill the upper bits with the sign bit (signed loads) or zero.
  // The sign bit is picked as the top set bit of the size mask so no
  // variable bit index is needed.
  function automatic logic [DWIDTH-1:0] extract(input logic [2*DWIDTH-1:0] win,
                                                input logic [OW-1:0]       off,
                                                input logic [2:0]          f3);
    logic [DWIDTH-1:0] low;
    logic [DWIDTH-1:0] mask;
    logic              sign;
    int                bits;
    low  = DWIDTH'(win >> {off, 3'b000});
    bits = 8 << f3[1:0];
    if (bits >= DWIDTH) mask = '1;
    else                mask = (DWIDTH'(1) << bits) - DWIDTH'(1);
    sign = ~f3[2] & (|(low & (mask ^ (mask >> 1))));
    return (low & mask) | ({DWIDTH{sign}} & ~mask);
  endfunction

  // Read strobe and address: first beat in the accept cycle, second beat
  // (if any) while in RD0 so its data lands in RD1.
  always_comb begin
    mem_re_c   = 1'b0;
    mem_addr_c = align(addr_q);
    case (state)
      IDLE: begin
        mem_re_c   = bus.req_valid & ~rst;
        mem_addr_c = align(bus.req_addr);
      end
`ifdef MISALIGNED_LOAD_EN
      RD0: begin
        if (legal_f3(f3_q) && crossing(off_q, f3_q)) begin
          mem_re_c   = ~rst;
          mem_addr_c = align(addr_q) + AWIDTH'(NB);
        end
      end
`endif
      default: begin
        mem_re_c   = 1'b0;
        mem_addr_c = align(addr_q);
      end
    endcase
  end

  assign bus.req_ready  = (state == IDLE) & ~rst;
  assign bus.mem_re     = mem_re_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.resp_valid = (state == RESP) & ~rst;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_fault = resp_fault_q;

  // Control FSM with registered response; reset aborts any load in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
`ifdef MISALIGNED_LOAD_EN
      beat0        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            f3_q   <= bus.req_funct3;
            state  <= RD0;
          end
        end
        RD0: begin
          if (!legal_f3(f3_q)) begin
            resp_data_q  <= '0;
            resp_fault_q <= 1'b1;
            state        <= RESP;
          end else if (crossing(off_q, f3_q)) begin
`ifdef MISALIGNED_LOAD_EN
            beat0 <= bus.mem_rdata;
            state <= RD1;
`else
            resp_data_q  <= '0;
            resp_fault_q <= 1'b1;
            state        <= RESP;
`endif
          end else begin
            resp_data_q  <= extract({{DWIDTH{1'b0}}, bus.mem_rdata}, off_q, f3_q);
            resp_fault_q <= 1'b0;
            state        <= RESP;
          end
        end
        RD1: begin
`ifdef MISALIGNED_LOAD_EN
          resp_data_q  <= extract({bus.mem_rdata, beat0}, off_q, f3_q);
          resp_fault_q <= 1'b0;
          state        <= RESP;
`else
          state <= IDLE;
`endif
        end
        RESP: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed testbench for load_align_unit (DWIDTH=32). Expectations follow
// the MISALIGNED_LOAD_EN setting of the build.
module tb_load_align_unit;

  logic clk = 1'b0;
  logic rst;

  load_align_unit_if #(.DWIDTH(32), .AWIDTH(32)) bus();

  load_align_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int re_total = 0;
  logic [31:0] re_log [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDDCC_BBAA;
      32'h0000_0104: return 32'h4433_2211;
      32'hFFFF_FFFC: return 32'h8877_6655;
      32'h0000_0000: return 32'h0302_0100;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Memory model: one-cycle read latency, logs every read address.
  always @(posedge clk) begin
    if (bus.mem_re) begin
      bus.mem_rdata          <= mem_word(bus.mem_addr);
      re_log[re_total % 64]  <= bus.mem_addr;
      re_total               <= re_total + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, check the same-cycle read, pass the accept edge.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       output int base);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    #1;
    base = re_total;
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_mem_re"},    64'(bus.mem_re),    64'd1);
    check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'(addr & 32'hFFFF_FFFC));
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Cycle index (accept cycle = 0) at which resp_valid is first seen.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      tick();
      lat++;
    end
  endtask

  task automatic complete(input string tag);
    tick();
    check({tag, "_done_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_done_ready"}, 64'(bus.req_ready),  64'd1);
  endtask

  // Full load with resp_ready high: latency, data, fault, read count/addresses.
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp_data, input logic exp_fault,
                      input int exp_lat, input int exp_reads, input logic [31:0] exp_a1);
    int base;
    int lat;
    issue(tag, f3, addr, base);
    wait_resp(lat);
    check({tag, "_latency"}, 64'(lat),            64'(exp_lat));
    check({tag, "_data"},    64'(bus.resp_data),  64'(exp_data));
    check({tag, "_fault"},   64'(bus.resp_fault), 64'(exp_fault));
    check({tag, "_reads"},   64'(re_total - base), 64'(exp_reads));
    check({tag, "_rd0_addr"}, 64'(re_log[base % 64]), 64'(addr & 32'hFFFF_FFFC));
    if (exp_reads > 1)
      check({tag, "_rd1_addr"}, 64'(re_log[(base + 1) % 64]), 64'(exp_a1));
    complete(tag);
  endtask

  initial begin
    int base;
    int lat;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_funct3 = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_req_ready",  64'(bus.req_ready),  64'd0);
    check("rst_mem_re",     64'(bus.mem_re),     64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_data",  64'(bus.resp_data),  64'd0);
    check("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);
    check("idle_mem_re",    64'(bus.mem_re),    64'd0);

    // Aligned / in-word accesses
    load("lb_103",  3'b000, 32'h103, 32'hFFFF_FFDD, 1'b0, 2, 1, 32'h0);
    load("lhu_102", 3'b101, 32'h102, 32'h0000_DDCC, 1'b0, 2, 1, 32'h0);
    load("lbu_101", 3'b100, 32'h101, 32'h0000_00BB, 1'b0, 2, 1, 32'h0);
    load("lh_100",  3'b001, 32'h100, 32'hFFFF_BBAA, 1'b0, 2, 1, 32'h0);
    load("lw_104",  3'b010, 32'h104, 32'h4433_2211, 1'b0, 2, 1, 32'h0);

    // Word-crossing accesses, including address wrap
`ifdef MISALIGNED_LOAD_EN
    load("lw_102",  3'b010, 32'h102, 32'h2211_DDCC, 1'b0, 3, 2, 32'h104);
    load("lh_103",  3'b001, 32'h103, 32'h0000_11DD, 1'b0, 3, 2, 32'h104);
    load("lw_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0201_0088, 1'b0, 3, 2, 32'h0);
`else
    load("lw_102",  3'b010, 32'h102, 32'h0, 1'b1, 2, 1, 32'h0);
    load("lh_103",  3'b001, 32'h103, 32'h0, 1'b1, 2, 1, 32'h0);
    load("lw_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b1, 2, 1, 32'h0);
`endif

    // Illegal funct3 on a 32-bit datapath
    load("ld_f3_011",  3'b011, 32'h100, 32'h0, 1'b1, 2, 1, 32'h0);
    load("lwu_f3_110", 3'b110, 32'h100, 32'h0, 1'b1, 2, 1, 32'h0);
    load("bad_f3_111", 3'b111, 32'h104, 32'h0, 1'b1, 2, 1, 32'h0);

    // Back-pressure: response held while resp_ready is low
    bus.resp_ready = 1'b0;
    issue("stall", 3'b000, 32'h100, base);
    wait_resp(lat);
    check("stall_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid",     64'(bus.resp_valid), 64'd1);
      check("stall_data",      64'(bus.resp_data),  64'hFFFF_FFAA);
      check("stall_req_ready", 64'(bus.req_ready),  64'd0);
      check("stall_mem_re",    64'(bus.mem_re),     64'd0);
    end
    bus.resp_ready = 1'b1;
    #1;
    check("stall_release_valid", 64'(bus.resp_valid), 64'd1);
    complete("stall");

    // Reset in the middle of a load: no response, next load works
    issue("abort", 3'b010, 32'h102, base);
`ifdef MISALIGNED_LOAD_EN
    tick();
`endif
    rst = 1'b1;
    tick();
    check("abort_rst_valid",  64'(bus.resp_valid), 64'd0);
    check("abort_rst_mem_re", 64'(bus.mem_re),     64'd0);
    check("abort_rst_data",   64'(bus.resp_data),  64'd0);
    rst = 1'b0;
    #1;
    check("abort_idle_ready", 64'(bus.req_ready),  64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    load("lb_after_abort", 3'b000, 32'h100, 32'hFFFF_FFAA, 1'b0, 2, 1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
